// File: rtl/dcs_select_ctrl.sv
// Sequencer for the one-hot clksel bus of a 4-input dynamic clock selector.
// Switches on request, waits for the DCS to settle, verifies the output toggles, reverts if not.
module dcs_select_ctrl #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MIN_EDGES      = 4,
  parameter int RESET_SEL      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic [3:0] clksel,
  input  logic       clkout_mon,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int EW = $clog2(MIN_EDGES) + 1;

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [EW-1:0] EDGE_MAX     = EW'(MIN_EDGES);
  localparam logic [1:0]    RESET_IDX    = 2'(RESET_SEL);
  localparam logic [3:0]    RESET_ONEHOT = 4'b0001 << RESET_SEL;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWITCH,
    S_VERIFY,
    S_DONE,
    S_REVERT,
    S_ERROR
  } state_t;

  state_t          state_reg;
  logic [3:0]      clksel_reg;
  logic [1:0]      cur_sel_reg;
  logic [1:0]      old_sel_reg;
  logic [1:0]      new_sel_reg;
  logic [SW-1:0]   settle_cnt_reg;
  logic [TW-1:0]   timeout_cnt_reg;
  logic [EW-1:0]   edge_cnt_reg;
  logic [2:0]      mon_sync_reg;
  logic            req_ready_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            err_reg;

  logic [3:0]      req_onehot;
  logic [3:0]      old_onehot;
  logic            mon_rise;
  logic [EW-1:0]   edge_cnt_next;
  logic [TW-1:0]   timeout_cnt_next;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dec
    assign req_onehot[gi] = (req_sel == 2'(gi));
    assign old_onehot[gi] = (old_sel_reg == 2'(gi));
  end

  // Stage [0] and [1] form the synchronizer; [2] holds the previous synchronized level.
  assign mon_rise = mon_sync_reg[1] & ~mon_sync_reg[2];

  always_comb begin
    edge_cnt_next    = edge_cnt_reg;
    timeout_cnt_next = timeout_cnt_reg;
    if (mon_rise && (edge_cnt_reg < EDGE_MAX))
      edge_cnt_next = edge_cnt_reg + 1'b1;
    if (timeout_cnt_reg < TIMEOUT_MAX)
      timeout_cnt_next = timeout_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      clksel_reg      <= RESET_ONEHOT;
      cur_sel_reg     <= RESET_IDX;
      old_sel_reg     <= RESET_IDX;
      new_sel_reg     <= RESET_IDX;
      settle_cnt_reg  <= '0;
      timeout_cnt_reg <= '0;
      edge_cnt_reg    <= '0;
      mon_sync_reg    <= '0;
      req_ready_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      mon_sync_reg <= {mon_sync_reg[1:0], clkout_mon};
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            old_sel_reg   <= cur_sel_reg;
            new_sel_reg   <= req_sel;
            if (req_sel == cur_sel_reg) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              // Single registered update from one one-hot code to another: never zero or multi-hot.
              clksel_reg     <= req_onehot;
              settle_cnt_reg <= '0;
              state_reg      <= S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            edge_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            state_reg       <= S_VERIFY;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        S_VERIFY: begin
          edge_cnt_reg    <= edge_cnt_next;
          timeout_cnt_reg <= timeout_cnt_next;
          // Edge count is tested first so a success on the last timeout cycle still wins.
          if (edge_cnt_next >= EDGE_MAX) begin
            cur_sel_reg <= new_sel_reg;
            done_reg    <= 1'b1;
            state_reg   <= S_DONE;
          end else if (timeout_cnt_next >= TIMEOUT_MAX) begin
            clksel_reg     <= old_onehot;
            settle_cnt_reg <= '0;
            state_reg      <= S_REVERT;
          end
        end
        S_DONE: begin
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
        S_REVERT: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            err_reg   <= 1'b1;
            state_reg <= S_ERROR;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        S_ERROR: begin
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
        default: begin
          clksel_reg    <= RESET_ONEHOT;
          cur_sel_reg   <= RESET_IDX;
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign clksel    = clksel_reg;
  assign cur_sel   = cur_sel_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_dcs_select_ctrl.sv
// Bench for dcs_select_ctrl: each request's whole output timeline is predicted from the
// monitor waveform the bench itself generates, then every cycle is compared against it.
module tb_dcs_select_ctrl;

  localparam int S    = 16;
  localparam int T    = 256;
  localparam int M    = 4;
  localparam int RS   = 0;
  localparam int NCYC = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic [3:0] clksel;
  logic       clkout_mon;
  logic [1:0] cur_sel;
  logic       busy;
  logic       done;
  logic       err;

  dcs_select_ctrl #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T),
    .MIN_EDGES     (M),
    .RESET_SEL     (RS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .clksel    (clksel),
    .clkout_mon(clkout_mon),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc;
  int n_checks;
  int n_errors;
  int sched_end;
  bit [1:0] model_cur;

  // wave[n] is the monitor level the DUT samples on posedge n.
  bit       wave    [NCYC];
  bit [1:0] e_sel   [NCYC];
  bit [1:0] e_cur   [NCYC];
  bit       e_ready [NCYC];
  bit       e_busy  [NCYC];
  bit       e_done  [NCYC];
  bit       e_err   [NCYC];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic fill(input int n0, input int n1, input bit [1:0] sel, input bit [1:0] cur,
                      input bit rdy, input bit bsy, input bit dn, input bit er);
    for (int n = n0; n <= n1; n++) begin
      e_sel[n] = sel; e_cur[n] = cur; e_ready[n] = rdy;
      e_busy[n] = bsy; e_done[n] = dn; e_err[n] = er;
    end
  endtask

  // One clock: advance, compare outputs after the edge, then drive the next monitor level.
  task automatic step();
    bit [1:0]   es, ec;
    bit         er, eb, ed, ee;
    logic [3:0] oh;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (cyc <= sched_end) begin
      es = e_sel[cyc]; ec = e_cur[cyc]; er = e_ready[cyc];
      eb = e_busy[cyc]; ed = e_done[cyc]; ee = e_err[cyc];
    end else begin
      es = model_cur; ec = model_cur; er = 1'b1; eb = 1'b0; ed = 1'b0; ee = 1'b0;
    end
    oh = 4'b0001 << es;
    check_val("onehot", $countones(clksel), 1);
    check_val("clksel", clksel, oh);
    check_val("cur_sel", cur_sel, ec);
    check_val("req_ready", req_ready, er);
    check_val("busy", busy, eb);
    check_val("done", done, ed);
    check_val("err", err, ee);
    if (cyc + 1 < NCYC) clkout_mon = wave[cyc + 1];
  endtask

  // mode: 0 stuck low, 1 stuck high, 2 random-rate toggle, 3 toggles only during settle,
  //       4 4th edge lands on the last verify cycle, 5 one cycle too late, 6 clk/8 toggle.
  task automatic run_txn(input bit [1:0] r, input int mode, input bit spurious, input int abort_at);
    int       a, h, ph, k, cnt, d, rv;
    bit [1:0] old;
    string    outcome;
    a   = cyc + 1;
    old = model_cur;
    h   = (mode == 6) ? 4 : int'($urandom_range(2, 6));
    ph  = int'($urandom_range(0, 11));
    k   = a + S + T - 14 + ((mode == 5) ? 1 : 0);
    for (int n = a + 1; n < a + 2 * S + T + 12 && n < NCYC; n++) begin
      case (mode)
        0:       wave[n] = 1'b0;
        1:       wave[n] = 1'b1;
        2, 6:    wave[n] = (((n + ph) / h) % 2) == 1;
        3:       wave[n] = (n <= a + S - 2) && ((n / 2) % 2 == 1);
        default: wave[n] = (n >= k) && (((n - k) / 2) % 2 == 0);
      endcase
    end

    if (r == old) begin
      fill(a, a, old, old, 1'b0, 1'b1, 1'b1, 1'b0);
      sched_end = a;
      outcome = "done (same index)";
    end else begin
      d = -1; cnt = 0;
      for (int n = a + S + 1; n <= a + S + T; n++) begin
        if (wave[n - 2] && !wave[n - 3]) cnt++;
        if (cnt >= M && d < 0) d = n;
      end
      if (d >= 0) begin
        fill(a, d - 1, r, old, 1'b0, 1'b1, 1'b0, 1'b0);
        fill(d, d, r, r, 1'b0, 1'b1, 1'b1, 1'b0);
        sched_end = d;
        model_cur = r;
        outcome = $sformatf("done after %0d cycles", d - a + 1);
      end else begin
        rv = a + S + T;
        fill(a, rv - 1, r, old, 1'b0, 1'b1, 1'b0, 1'b0);
        fill(rv, rv + S - 1, old, old, 1'b0, 1'b1, 1'b0, 1'b0);
        fill(rv + S, rv + S, old, old, 1'b0, 1'b1, 1'b0, 1'b1);
        sched_end = rv + S;
        outcome = "err, reverted";
      end
    end

    req_valid = 1'b1;
    req_sel   = r;
    step();
    req_valid = 1'b0;
    while (cyc < sched_end) begin
      if (abort_at > 0 && cyc == a + abort_at) begin
        rst       = 1'b1;
        model_cur = 2'(RS);
        sched_end = cyc;
        step();
        rst     = 1'b0;
        outcome = "reset mid-verify";
        break;
      end
      if (spurious && cyc >= a + 2 && cyc <= a + S - 4) begin
        req_valid = 1'b1;
        req_sel   = 2'($urandom_range(0, 3));
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    $display("txn cyc=%0d sel=%0d from=%0d mode=%0d spurious=%0d -> %s cur_sel=%0d",
             a, r, old, mode, spurious, outcome, model_cur);
    repeat ($urandom_range(1, 4)) step();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sel    = 2'd0;
    clkout_mon = 1'b0;
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    sched_end  = -1;
    model_cur  = 2'(RS);
    repeat (3) step();
    rst = 1'b0;
    repeat (50) step();

    run_txn(2'd2, 6, 1'b0, 0);      // clk/8 monitor: success
    run_txn(2'd0, 6, 1'b0, 0);
    run_txn(2'd3, 0, 1'b0, 0);      // dead clock: revert to 0
    run_txn(2'd0, 0, 1'b0, 0);      // same index
    run_txn(2'd2, 6, 1'b1, 0);      // extra requests during settle are ignored
    run_txn(2'd1, 0, 1'b0, S + 20); // reset while verifying
    run_txn(2'd3, 4, 1'b0, 0);      // success on the final verify cycle
    run_txn(2'd1, 5, 1'b0, 0);      // 4th edge one cycle late: revert
    run_txn(2'd2, 3, 1'b0, 0);      // edges only while settling: revert

    for (int i = 0; i < 14; i++)
      run_txn(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
